rr_gnt_arb: RTL and testbench
=============================

Name: rr_gnt_arb

Overview:
- Grant stage directly downstream of the bit-serial priority selector.
- Issues the one-cycle `update` pulse that loads a new request snapshot into the selector, then waits for its `ready` pulse.
- On `ready`, samples the selector's tie-set of highest-priority requests (`req_in`) and grants exactly one port, using round-robin among tied ports.
- Holds the grant until the port signals completion or a watchdog expires, then starts the next round.

Parameters:
- N, 4, number of input ports (selector width).
- P, 16, number of priority levels; priority field width W = $clog2(P).
- TMO, 255, maximum cycles a grant is held without `done` before forced release; counter width $clog2(TMO+1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- req_pending  input  1  at least one upstream FIFO is non-empty.
- update  output  1  one-cycle pulse that loads the selector with a new snapshot.
- ready  input  1  selector result valid; one-cycle pulse.
- req_in  input  N  selector tie-set; bit i set means port i holds the maximum priority.
- prio_in  input  N x W  selector masked priority per port.
- done  input  1  granted port has finished its transfer.
- gnt  output  N  one-hot grant, registered.
- gnt_valid  output  1  `gnt` and `gnt_prio` are valid.
- gnt_prio  output  W  priority of the granted port, registered.
- tmo_err  output  1  one-cycle pulse on watchdog release.

Behaviour:
- Reset (reset=0 at a clk edge):
  - state=IDLE, ptr=0, cnt=0.
  - `update`, `gnt`, `gnt_valid`, `gnt_prio`, `tmo_err` all 0.
  - A reset during any state aborts the round immediately; no `tmo_err` is generated.
- Outputs: all outputs are registered, which means a value is driven the cycle after the decision that produces it.
- States:
  - IDLE: if req_pending=1, next state is LOAD; otherwise stay in IDLE.
  - LOAD: `update`=1 for exactly this one cycle; next state is WAIT.
  - WAIT:
    - Wait for ready=1. The selector latency is fixed: `ready` arrives 4 cycles after the `update` cycle.
    - On ready with req_in=0: no grant; next state is IDLE.
    - On ready with req_in≠0: the winner idx is the first set bit of req_in, searching upward from ptr and wrapping modulo N.
    - Same transition registers gnt=1<<idx, gnt_prio=prio_in[idx], gnt_valid=1, cnt=0. Next state is GRANT.
  - GRANT: outputs held stable; cnt increments every cycle.
    - Completion: done=1, including in the first GRANT cycle.
      - Clear `gnt` and `gnt_valid`; set ptr=(idx+1) mod N.
      - Next state is LOAD if req_pending=1, otherwise IDLE.
    - Watchdog: cnt==TMO with done=0.
      - Same release and ptr update as completion; tmo_err=1 for one cycle.
      - Next state is IDLE.
    - Simultaneous: done=1 and cnt==TMO together is a normal completion; tmo_err stays 0.
- Ignored inputs:
  - `ready` outside WAIT.
  - `done` outside GRANT.
  - `req_pending` outside IDLE and the GRANT exit.
- Round-robin wrap-around: ptr=N-1 searches N-1, 0, 1, … and so on; ptr advances only on a release.
- Grant invariants:
  - `gnt` is always one-hot or zero.
  - gnt_valid equals |gnt.
  - At most one grant is outstanding.
- Width rule: ptr and idx are $clog2(N) bits. The increment wraps naturally when N is a power of 2; otherwise compare against N-1 explicitly.

Decomposition:
- Package `arb_pkg`:
  - State enum {IDLE, LOAD, WAIT, GRANT}.
  - Localparams for W and the ptr width.
  - Shared with the selector for P/N consistency.
- One sub-module `rr_pick`: purely combinational rotate-and-priority-encode.
  - Inputs: req[N], ptr.
  - Outputs: idx, found.
  - Reusable by later arbiters.

Test Plan:
- Single port: req_pending=1, ready at cycle 5 with req_in=4'b0100, prio_in[2]=4'hB.
  - Expect update=1 in cycle 1 only.
  - Expect gnt=0100, gnt_prio=B, gnt_valid=1 from cycle 6.
  - done at cycle 9 → gnt=0 at cycle 10; ptr=3.
- Round-robin tie: req_in=4'b1011 on 4 consecutive rounds starting at ptr=0.
  - Expect grants 0001, 0010, 1000, 0001.
- Empty snapshot: ready with req_in=0.
  - Expect no grant, return to IDLE, ptr unchanged.
- Watchdog with TMO=8: grant issued, done never asserted.
  - Expect gnt cleared and tmo_err=1 for one cycle, 9 cycles after grant entry.
- Edge events:
  - done in the first GRANT cycle while req_pending=1 → LOAD next, `update` pulse on the following cycle.
  - Stray `ready` or `done` pulses in IDLE cause no state change.
- Mid-round reset: reset=0 during GRANT and during WAIT.
  - Expect all outputs 0 and state IDLE on the next cycle.
  - Expect ptr=0 and no tmo_err.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and sizing for the grant arbiter and its selector.
// Holds the FSM state enum, default widths and a pointer-width helper.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    GRANT
  } arb_state_e;

  localparam int ARB_N   = 4;
  localparam int ARB_P   = 16;
  localparam int ARB_TMO = 255;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ARB_W  = $clog2(ARB_P);
  localparam int ARB_PW = ptr_w(ARB_N);

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of req at or above ptr, wrapping.
// Ports: req (N), ptr (PW) in; idx (PW) winner, found (any req set) out.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          found
);

  localparam int SW = PW + 1;

  logic [SW-1:0] pos;

  // Scan offsets from far to near so the
  // nearest set bit above ptr is written last.
  always_comb begin
    idx   = '0;
    pos   = '0;
    found = |req;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + SW'(k);
      if (pos >= SW'(N)) begin
        pos = pos - SW'(N);
      end
      if (req[pos[PW-1:0]]) begin
        idx = pos[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_gnt_arb.sv
// Round-robin grant stage behind the priority selector: load, wait, grant.
// Ports: clk, reset(n), req_pending, ready, req_in, prio_in, done in;
//        update, gnt, gnt_valid, gnt_prio, tmo_err out (all registered).
module rr_gnt_arb
  import arb_pkg::*;
#(
  parameter int N   = ARB_N,
  parameter int P   = ARB_P,
  parameter int TMO = ARB_TMO
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_pending,
  output logic                    update,
  input  logic                    ready,
  input  logic [N-1:0]            req_in,
  input  logic [N*$clog2(P)-1:0]  prio_in,
  input  logic                    done,
  output logic [N-1:0]            gnt,
  output logic                    gnt_valid,
  output logic [$clog2(P)-1:0]    gnt_prio,
  output logic                    tmo_err
);

  localparam int W  = $clog2(P);
  localparam int PW = ptr_w(N);
  localparam int CW = $clog2(TMO + 1);

  arb_state_e    state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] gidx, gidx_n;
  logic [CW-1:0] cnt, cnt_n;

  logic          update_n;
  logic [N-1:0]  gnt_n;
  logic          gnt_valid_n;
  logic [W-1:0]  gnt_prio_n;
  logic          tmo_err_n;

  logic [PW-1:0] pick_idx;
  logic          pick_found;
  logic [W-1:0]  pick_prio;
  logic [PW-1:0] ptr_adv;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req   (req_in),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    pick_prio = '0;
    for (int i = 0; i < N; i++) begin
      if (PW'(i) == pick_idx) begin
        pick_prio = prio_in[i*W +: W];
      end
    end
  end

  // Explicit wrap keeps non-power-of-two N correct.
  always_comb begin
    if (gidx == PW'(N - 1)) begin
      ptr_adv = '0;
    end else begin
      ptr_adv = gidx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      gidx      <= '0;
      cnt       <= '0;
      update    <= 1'b0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_prio  <= '0;
      tmo_err   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gidx      <= gidx_n;
      cnt       <= cnt_n;
      update    <= update_n;
      gnt       <= gnt_n;
      gnt_valid <= gnt_valid_n;
      gnt_prio  <= gnt_prio_n;
      tmo_err   <= tmo_err_n;
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    gidx_n      = gidx;
    cnt_n       = cnt;
    gnt_n       = gnt;
    gnt_valid_n = gnt_valid;
    gnt_prio_n  = gnt_prio;
    tmo_err_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_pending) begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        state_n = WAIT;
      end
      WAIT: begin
        if (ready) begin
          if (pick_found) begin
            gnt_n       = N'(1) << pick_idx;
            gnt_prio_n  = pick_prio;
            gnt_valid_n = 1'b1;
            gidx_n      = pick_idx;
            cnt_n       = '0;
            state_n     = GRANT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      GRANT: begin
        cnt_n = cnt + CW'(1);
        // done wins over a simultaneous watchdog expiry.
        if (done) begin
          gnt_n       = '0;
          gnt_valid_n = 1'b0;
          ptr_n       = ptr_adv;
          cnt_n       = '0;
          state_n     = req_pending ? LOAD : IDLE;
        end else if (cnt == CW'(TMO)) begin
          gnt_n       = '0;
          gnt_valid_n = 1'b0;
          ptr_n       = ptr_adv;
          cnt_n       = '0;
          tmo_err_n   = 1'b1;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    update_n = (state_n == LOAD);
  end

endmodule

// File: tb/tb_rr_gnt_arb.sv
// Self-checking bench for rr_gnt_arb: directed rounds plus random rounds.
// A transaction-level model predicts winners, release timing and tmo_err.
module tb_rr_gnt_arb;

  localparam int N   = 4;
  localparam int P   = 16;
  localparam int TMO = 8;

  logic        clk;
  logic        reset;
  logic        req_pending;
  logic        update;
  logic        ready;
  logic [3:0]  req_in;
  logic [15:0] prio_in;
  logic        done;
  logic [3:0]  gnt;
  logic        gnt_valid;
  logic [3:0]  gnt_prio;
  logic        tmo_err;

  int tests;
  int fails;
  int mptr;
  bit in_load;

  rr_gnt_arb #(
    .N   (N),
    .P   (P),
    .TMO (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_pending (req_pending),
    .update      (update),
    .ready       (ready),
    .req_in      (req_in),
    .prio_in     (prio_in),
    .done        (done),
    .gnt         (gnt),
    .gnt_valid   (gnt_valid),
    .gnt_prio    (gnt_prio),
    .tmo_err     (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] rq, input int p);
    for (int k = 0; k < N; k++) begin
      if (rq[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_update"}, update, 0);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_gvalid"}, gnt_valid, 0);
    chk({tag, "_gprio"}, gnt_prio, 0);
    chk({tag, "_tmo"}, tmo_err, 0);
  endtask

  // One round: update pulse, ready 4 cycles later, grant held d
  // cycles before done (d > TMO means done never comes).
  task automatic do_round(input logic [3:0] rq,
                          input logic [15:0] pr,
                          input int d,
                          input bit rp_exit);
    int w;
    bit to;
    logic [3:0] eg;
    if (!in_load) begin
      req_pending = 1'b1;
      tick();
      req_pending = 1'b0;
    end
    in_load = 1'b0;
    chk("update_pulse", update, 1);
    tick();
    chk("update_low", update, 0);
    tick();
    tick();
    tick();
    ready   = 1'b1;
    req_in  = rq;
    prio_in = pr;
    tick();
    ready   = 1'b0;
    req_in  = 4'($urandom);
    prio_in = 16'($urandom);
    if (rq == 4'b0) begin
      chk("empty_gnt", gnt, 0);
      chk("empty_valid", gnt_valid, 0);
      tick();
      chk("empty_update", update, 0);
      chk("empty_gnt2", gnt, 0);
      return;
    end
    w  = pick(rq, mptr);
    eg = 4'(1 << w);
    chk("gnt", gnt, eg);
    chk("gnt_valid", gnt_valid, 1);
    chk("gnt_prio", gnt_prio, (pr >> (4 * w)) & 16'hF);
    to = 1'b0;
    for (int k = 0; ; k++) begin
      if (k == d) begin
        done        = 1'b1;
        req_pending = rp_exit;
        tick();
        done        = 1'b0;
        req_pending = 1'b0;
        break;
      end else if (k == TMO) begin
        to = 1'b1;
        req_pending = 1'b0;
        tick();
        break;
      end
      ready       = 1'($urandom_range(0, 1));
      req_pending = 1'($urandom_range(0, 1));
      tick();
      ready       = 1'b0;
      req_pending = 1'b0;
      chk("hold_gnt", gnt, eg);
      chk("hold_valid", gnt_valid, 1);
      chk("hold_tmo", tmo_err, 0);
    end
    ready = 1'b0;
    chk("rel_gnt", gnt, 0);
    chk("rel_valid", gnt_valid, 0);
    chk("rel_tmo", tmo_err, to);
    mptr = (w + 1) % N;
    if (!to && rp_exit) begin
      chk("reload_update", update, 1);
      in_load = 1'b1;
    end else begin
      chk("rel_update", update, 0);
      tick();
      chk("post_tmo", tmo_err, 0);
      chk("post_update", update, 0);
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    mptr        = 0;
    in_load     = 1'b0;
    reset       = 1'b0;
    req_pending = 1'b0;
    ready       = 1'b0;
    req_in      = '0;
    prio_in     = '0;
    done        = 1'b0;
    tick();
    tick();
    chk_idle_outs("reset");
    reset = 1'b1;
    tick();
    chk_idle_outs("idle");

    // Single port: grant port 2, prio B, done three cycles in.
    do_round(4'b0100, 16'h0B00, 3, 1'b0);

    // Round-robin tie from ptr 0 after a fresh reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mptr  = 0;
    for (int r = 0; r < 4; r++) begin
      do_round(4'b1011, 16'h4321, 1, 1'b0);
    end

    // Empty snapshot leaves ptr alone.
    do_round(4'b0000, 16'h0, 0, 1'b0);
    do_round(4'b1111, 16'hFEDC, 2, 1'b0);

    // Watchdog and simultaneous done at expiry.
    do_round(4'b0110, 16'h1234, 50, 1'b0);
    do_round(4'b1001, 16'h5678, TMO, 1'b0);

    // done in first grant cycle with more work pending.
    do_round(4'b0011, 16'h00A5, 0, 1'b1);
    do_round(4'b1100, 16'h9000, 1, 1'b0);

    // Stray ready/done while idle.
    ready  = 1'b1;
    done   = 1'b1;
    req_in = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stray_update", update, 0);
      chk("stray_gnt", gnt, 0);
    end
    ready = 1'b0;
    done  = 1'b0;
    tick();
    chk("stray_end", update, 0);

    // Reset during WAIT.
    req_pending = 1'b1;
    tick();
    req_pending = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mptr  = 0;
    chk_idle_outs("rst_wait");
    tick();
    chk_idle_outs("rst_wait2");

    // Reset during GRANT; no late watchdog.
    do_round(4'b0010, 16'h0, 1, 1'b0);
    req_pending = 1'b1;
    tick();
    req_pending = 1'b0;
    repeat (4) tick();
    ready  = 1'b1;
    req_in = 4'b1111;
    tick();
    ready  = 1'b0;
    chk("rst_g_gnt", gnt, 4'(1 << pick(4'b1111, mptr)));
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mptr  = 0;
    chk_idle_outs("rst_grant");
    for (int k = 0; k < TMO + 3; k++) begin
      tick();
      chk("rst_g_tmo", tmo_err, 0);
      chk("rst_g_gnt0", gnt, 0);
    end
    do_round(4'b1111, 16'h7777, 0, 1'b0);

    // Random rounds against the model.
    for (int r = 0; r < 40; r++) begin
      do_round(4'($urandom_range(0, 15)),
               16'($urandom),
               $urandom_range(0, 11),
               1'($urandom_range(0, 1)));
    end
    if (in_load) begin
      do_round(4'b0101, 16'h0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
